// File: rtl/ka_pkg.sv
// Shared definitions for the slice-address packer.
//   SELOU_DEF / SLICES_DEF / BADDR_DEF : default field widths and slice count
//   KA_W                               : packed word width for the defaults
//   CNT_W_DEF                          : slice counter width for the defaults
//   ka_state_e                         : packer control states
package ka_pkg;

   localparam int unsigned SELOU_DEF  = 4;
   localparam int unsigned SLICES_DEF = 4;
   localparam int unsigned BADDR_DEF  = 8;
   localparam int unsigned KA_W       = SELOU_DEF + SLICES_DEF * BADDR_DEF;
   localparam int unsigned CNT_W_DEF  = $clog2(SLICES_DEF);

   // FILL: assembling, no output; HOLD: output valid, assembly idle;
   // HOLD_FILL: output valid while the next word assembles.
   typedef enum logic [1:0] {
      FILL      = 2'd0,
      HOLD      = 2'd1,
      HOLD_FILL = 2'd2
   } ka_state_e;

endpackage

// File: rtl/ka_pack_dat.sv
// Packs one slice address per beat plus a first-beat selector into a wide word
// and presents it on a valid/ready handshake to the decode stage.
//   clk, reset        : clock, synchronous active-high reset
//   s_sel/s_addr      : selector (first beat only) and per-beat slice address
//   s_last, s_valid   : end-of-word marker and beat valid
//   s_ready           : beat accepted this cycle when s_valid is also high
//   t_ka_dat, t_valid : packed word {sel, slice[SLICES-1] .. slice[0]} and valid
//   t_ready           : downstream accepts the word
//   short_err         : one-cycle pulse when a word closed early on s_last
module ka_pack_dat
   import ka_pkg::*;
#(
   parameter int unsigned SELOU  = SELOU_DEF,
   parameter int unsigned SLICES = SLICES_DEF,
   parameter int unsigned BADDR  = BADDR_DEF
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [SELOU-1:0]                s_sel,
   input  logic [BADDR-1:0]                s_addr,
   input  logic                            s_last,
   input  logic                            s_valid,
   output logic                            s_ready,
   output logic [SELOU+SLICES*BADDR-1:0]   t_ka_dat,
   output logic                            t_valid,
   input  logic                            t_ready,
   output logic                            short_err
);

   localparam int unsigned CNT_W = $clog2(SLICES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLICES - 1);

   ka_state_e                     state_q, state_nxt;
   logic [CNT_W-1:0]              cnt_q;
   logic [SELOU-1:0]              sel_q;
   logic [SLICES-1:0][BADDR-1:0]  addr_q;

   logic [SELOU-1:0]              sel_c;
   logic [SLICES-1:0][BADDR-1:0]  addr_c;
   logic                          would_close_c;
   logic                          acc_c;
   logic                          close_c;

   // Next-state, ready and assembly-word view including the current beat.
   always_comb begin
      state_nxt     = state_q;
      sel_c         = sel_q;
      addr_c        = addr_q;
      s_ready       = 1'b0;
      would_close_c = (cnt_q == CNT_LAST) || s_last;

      // While an output word is held, a closing beat can only be taken if the
      // held word leaves this cycle; otherwise the output would be overwritten.
      case (state_q)
         FILL:            s_ready = 1'b1;
         HOLD, HOLD_FILL: s_ready = t_ready || !would_close_c;
         default:         s_ready = 1'b0;
      endcase
      if (reset) begin
         s_ready = 1'b0;
      end

      acc_c   = s_valid && s_ready;
      close_c = acc_c && would_close_c;

      // First beat latches the selector and clears the upper slices.
      if (cnt_q == '0) begin
         sel_c  = s_sel;
         addr_c = '0;
      end
      addr_c[cnt_q] = s_addr;

      case (state_q)
         FILL: begin
            if (close_c) state_nxt = HOLD;
         end
         HOLD, HOLD_FILL: begin
            if (close_c)      state_nxt = HOLD;
            else if (t_ready) state_nxt = FILL;
            else if (acc_c)   state_nxt = HOLD_FILL;
         end
         default: state_nxt = FILL;
      endcase
   end

   // State, counter, assembly and output registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= FILL;
         cnt_q     <= '0;
         sel_q     <= '0;
         addr_q    <= '0;
         t_ka_dat  <= '0;
         t_valid   <= 1'b0;
         short_err <= 1'b0;
      end else begin
         state_q   <= state_nxt;
         t_valid   <= (state_nxt != FILL);
         short_err <= close_c && (cnt_q != CNT_LAST);
         if (acc_c) begin
            sel_q  <= sel_c;
            addr_q <= addr_c;
            cnt_q  <= close_c ? '0 : cnt_q + CNT_W'(1);
         end
         if (close_c) begin
            t_ka_dat <= {sel_c, addr_c};
         end
      end
   end

endmodule

// File: tb/tb_ka_pack_dat.sv
// Self-checking bench for ka_pack_dat (SELOU=4, SLICES=4, BADDR=8).
module tb_ka_pack_dat;

   logic        clk = 1'b0;
   logic        reset;
   logic [3:0]  s_sel;
   logic [7:0]  s_addr;
   logic        s_last;
   logic        s_valid;
   logic        s_ready;
   logic [35:0] t_ka_dat;
   logic        t_valid;
   logic        t_ready;
   logic        short_err;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   logic [35:0] sb_dat[$];
   bit          sb_short[$];
   int          hs_cyc[$];

   bit          fresh = 1'b1;
   bit          prev_hold = 1'b0;
   logic [35:0] prev_dat = '0;

   ka_pack_dat #(.SELOU(4), .SLICES(4), .BADDR(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .s_sel     (s_sel),
      .s_addr    (s_addr),
      .s_last    (s_last),
      .s_valid   (s_valid),
      .s_ready   (s_ready),
      .t_ka_dat  (t_ka_dat),
      .t_valid   (t_valid),
      .t_ready   (t_ready),
      .short_err (short_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Output monitor: short_err alignment, hold stability, scoreboard pops.
   always @(negedge clk) begin
      if (!reset) begin
         if (t_valid && fresh && sb_short.size() > 0) begin
            tests++;
            if (short_err !== sb_short[0]) begin
               fails++;
               $display("FAIL short_err_align: got %b want %b", short_err, sb_short[0]);
            end
         end else if (short_err !== 1'b0) begin
            tests++;
            fails++;
            $display("FAIL short_err_spurious: got %b want 0", short_err);
         end
         if (prev_hold && t_valid) begin
            tests++;
            if (t_ka_dat !== prev_dat) begin
               fails++;
               $display("FAIL hold_stable: got %h want %h", t_ka_dat, prev_dat);
            end
         end
         if (t_valid && t_ready) begin
            tests++;
            if (sb_dat.size() == 0) begin
               fails++;
               $display("FAIL unexpected_word: got %h want none", t_ka_dat);
            end else begin
               if (t_ka_dat !== sb_dat[0]) begin
                  fails++;
                  $display("FAIL word_data: got %h want %h", t_ka_dat, sb_dat[0]);
               end
               void'(sb_dat.pop_front());
               void'(sb_short.pop_front());
            end
            hs_cyc.push_back(cyc);
         end
      end
      fresh     = !t_valid || t_ready || reset;
      prev_hold = t_valid && !t_ready && !reset;
      prev_dat  = t_ka_dat;
   end

   // Streams one word; pushes its expected packing when push is set.
   task automatic send_word(input logic [3:0] sel, input logic [31:0] addrs,
                            input int nbeats, input bit last, input bit push);
      logic [31:0] exp_addr;
      bit          accepted;
      int          w;
      exp_addr = '0;
      for (int k = 0; k < nbeats; k++) exp_addr[k*8 +: 8] = addrs[k*8 +: 8];
      if (push) begin
         sb_dat.push_back({sel, exp_addr});
         sb_short.push_back(last && (nbeats < 4));
      end
      for (int k = 0; k < nbeats; k++) begin
         s_valid  = 1'b1;
         s_sel    = (k == 0) ? sel : 4'($urandom_range(0, 15));
         s_addr   = addrs[k*8 +: 8];
         s_last   = last && (k == nbeats - 1);
         accepted = 1'b0;
         w        = 0;
         while (!accepted && w < 64) begin
            @(negedge clk);
            if (s_ready) accepted = 1'b1;
            @(posedge clk);
            #1;
            w++;
         end
         if (!accepted) begin
            tests++;
            fails++;
            $display("FAIL beat_timeout: beat %0d got no s_ready want accept", k);
            break;
         end
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_addr  = 8'($urandom_range(0, 255));
   endtask

   task automatic test_reset();
      reset   = 1'b1;
      s_valid = 1'b0;
      s_last  = 1'b0;
      s_sel   = '0;
      s_addr  = '0;
      t_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      @(negedge clk);
      tests += 4;
      if (s_ready !== 1'b0) begin fails++; $display("FAIL rst_s_ready: got %b want 0", s_ready); end
      if (t_valid !== 1'b0) begin fails++; $display("FAIL rst_t_valid: got %b want 0", t_valid); end
      if (t_ka_dat !== 36'h0) begin fails++; $display("FAIL rst_dat: got %h want 0", t_ka_dat); end
      if (short_err !== 1'b0) begin fails++; $display("FAIL rst_short: got %b want 0", short_err); end
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      tests++;
      if (s_ready !== 1'b1) begin fails++; $display("FAIL post_rst_s_ready: got %b want 1", s_ready); end
      repeat (3) @(negedge clk);
      tests++;
      if (t_valid !== 1'b0) begin fails++; $display("FAIL idle_t_valid: got %b want 0", t_valid); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_full_word();
      t_ready = 1'b1;
      send_word(4'hA, 32'h44332211, 4, 1'b1, 1'b1);
      tests += 2;
      if (t_valid !== 1'b1) begin fails++; $display("FAIL full_latency: t_valid %b want 1", t_valid); end
      if (short_err !== 1'b0) begin fails++; $display("FAIL full_short: got %b want 0", short_err); end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_short_word();
      t_ready = 1'b1;
      send_word(4'h5, 32'h00000201, 2, 1'b1, 1'b1);
      tests += 2;
      if (t_valid !== 1'b1) begin fails++; $display("FAIL short_latency: t_valid %b want 1", t_valid); end
      if (short_err !== 1'b1) begin fails++; $display("FAIL short_pulse: got %b want 1", short_err); end
      @(posedge clk);
      #1;
      tests++;
      if (short_err !== 1'b0) begin fails++; $display("FAIL short_width: got %b want 0", short_err); end
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_back_pressure();
      t_ready = 1'b0;
      fork
         begin
            send_word(4'h1, 32'hD4C3B2A1, 4, 1'b1, 1'b1);
            send_word(4'h2, 32'h87654321, 4, 1'b1, 1'b1);
         end
         begin
            repeat (12) @(posedge clk);
            @(negedge clk);
            tests += 3;
            if (s_ready !== 1'b0) begin fails++; $display("FAIL bp_s_ready: got %b want 0", s_ready); end
            if (t_valid !== 1'b1) begin fails++; $display("FAIL bp_t_valid: got %b want 1", t_valid); end
            if (t_ka_dat !== 36'h1D4C3B2A1) begin
               fails++;
               $display("FAIL bp_held: got %h want %h", t_ka_dat, 36'h1D4C3B2A1);
            end
            @(posedge clk);
            #1;
            t_ready = 1'b1;
         end
      join
      repeat (4) @(posedge clk);
      #1;
      tests++;
      if (sb_dat.size() != 0) begin fails++; $display("FAIL bp_drain: %0d left want 0", sb_dat.size()); end
   endtask

   task automatic test_back_to_back();
      t_ready = 1'b1;
      hs_cyc.delete();
      for (int i = 0; i < 8; i++) begin
         send_word(4'(i), $urandom, 4, 1'b1, 1'b1);
      end
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (hs_cyc.size() != 8) begin
         fails++;
         $display("FAIL b2b_count: got %0d want 8", hs_cyc.size());
      end else begin
         for (int i = 1; i < 8; i++) begin
            tests++;
            if (hs_cyc[i] - hs_cyc[i-1] != 4) begin
               fails++;
               $display("FAIL b2b_gap: word %0d got %0d want 4", i, hs_cyc[i] - hs_cyc[i-1]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_word();
      t_ready = 1'b1;
      send_word(4'h9, 32'h00007766, 2, 1'b0, 1'b0);
      reset = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      tests += 2;
      if (t_valid !== 1'b0) begin fails++; $display("FAIL midrst_t_valid: got %b want 0", t_valid); end
      if (t_ka_dat !== 36'h0) begin fails++; $display("FAIL midrst_dat: got %h want 0", t_ka_dat); end
      @(posedge clk);
      #1;
      send_word(4'h3, 32'hDDCCBBAA, 4, 1'b1, 1'b1);
      repeat (3) @(posedge clk);
      #1;
      tests++;
      if (sb_dat.size() != 0) begin fails++; $display("FAIL midrst_drain: %0d left want 0", sb_dat.size()); end
   endtask

   initial begin
      test_reset();
      test_full_word();
      test_short_word();
      test_back_pressure();
      test_back_to_back();
      test_reset_mid_word();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
